// File: rtl/sram_ctrl.sv
// sram_ctrl: registered multi-cycle controller for one asynchronous SRAM bank.
// Optional macro SRAM_CTRL_B2B_EN chains a pending request from FINISH straight into SETUP.
module sram_ctrl #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] DataOut,
  output logic              Busy,
  output logic              Done,
  output logic              Ram_EN,
  output logic              Ram_OE,
  output logic              Ram_WE,
  output logic [ADDR_W-1:0] Ram_address,
  inout  wire  [DATA_W-1:0] Ram_data
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, FINISH} state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic              is_wr_reg, is_wr_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [DATA_W-1:0] dout_reg, dout_next;
  logic              en_n_reg, en_n_next;
  logic              oe_n_reg, oe_n_next;
  logic              we_n_reg, we_n_next;
  logic              drive_reg, drive_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              accept;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    is_wr_next = is_wr_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    dout_next  = dout_reg;
    accept     = 1'b0;

    case (state_reg)
      IDLE: accept = MemWrite | MemRead;
      SETUP: begin
        cnt_next   = WAIT_LD;
        state_next = ACCESS;
      end
      ACCESS: begin
        if (cnt_reg == 4'd0) begin
          state_next = FINISH;
          // OE is still low at this edge, so the SRAM is still driving the bus.
          if (!is_wr_reg) dout_next = Ram_data;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      FINISH: begin
        state_next = IDLE;
`ifdef SRAM_CTRL_B2B_EN
        accept = MemWrite | MemRead;
`endif
      end
      default: state_next = IDLE;
    endcase

    if (accept) begin
      state_next = SETUP;
      is_wr_next = MemWrite;
      addr_next  = Addr;
      wdata_next = DataIn;
    end

    // Strobes are decoded from the next state so every pin comes straight off a flop.
    en_n_next  = 1'b1;
    oe_n_next  = 1'b1;
    we_n_next  = 1'b1;
    drive_next = 1'b0;
    case (state_next)
      SETUP: begin
        en_n_next  = 1'b0;
        oe_n_next  = is_wr_next;
        drive_next = is_wr_next;
      end
      ACCESS: begin
        en_n_next  = 1'b0;
        oe_n_next  = is_wr_next;
        we_n_next  = !is_wr_next;
        drive_next = is_wr_next;
      end
      FINISH: begin
        // A write keeps the chip selected and the bus driven as data hold.
        en_n_next  = !is_wr_next;
        drive_next = is_wr_next;
      end
      default: ;
    endcase
    busy_next = (state_next != IDLE);
    done_next = (state_next == FINISH);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      is_wr_reg <= 1'b0;
      addr_reg  <= '0;
      dout_reg  <= '0;
      en_n_reg  <= 1'b1;
      oe_n_reg  <= 1'b1;
      we_n_reg  <= 1'b1;
      drive_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      is_wr_reg <= is_wr_next;
      addr_reg  <= addr_next;
      dout_reg  <= dout_next;
      en_n_reg  <= en_n_next;
      oe_n_reg  <= oe_n_next;
      we_n_reg  <= we_n_next;
      drive_reg <= drive_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  // Write data is only ever put on the bus while drive_reg is set, so it needs no reset.
  always_ff @(posedge Clk) begin
    wdata_reg <= wdata_next;
  end

  assign Ram_data    = drive_reg ? wdata_reg : {DATA_W{1'bz}};
  assign DataOut     = dout_reg;
  assign Busy        = busy_reg;
  assign Done        = done_reg;
  assign Ram_EN      = en_n_reg;
  assign Ram_OE      = oe_n_reg;
  assign Ram_WE      = we_n_reg;
  assign Ram_address = addr_reg;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: three sram_ctrl instances (WAIT_CYCLES 1, 0, 15) with SRAM models and a scoreboard.
// Build with SRAM_CTRL_B2B_EN defined to expect chained accesses from FINISH.
`timescale 1ns/1ps
module tb_sram_ctrl;
  localparam int N = 3;
  localparam logic [15:0] PROBE = 16'h8181;

  typedef struct {
    int          inst;
    bit          wr;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [15:0] dout;
    int          acc;
    int          done_cyc;
  } rec_t;

  rec_t  q[$];
  rec_t  cur;
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    strobe_bad = 0;
  string strobe_msg = "";
  int    done_seen[N];
  int    t_mon, w_mon;
  logic  exp_en, exp_oe, exp_we;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read[N], mem_write[N], probe_en[N];
  logic [17:0] addr[N];
  logic [15:0] data_in[N], data_out[N], exp_dout[N];
  logic        busy[N], done[N], ram_en[N], ram_oe[N], ram_we[N];
  logic [17:0] ram_address[N];
  wire  [15:0] bus_obs[N];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wof(input int k);
    case (k)
      0:       return 1;
      1:       return 0;
      default: return 15;
    endcase
  endfunction

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    wire  [15:0] rd;
    logic [15:0] mem [256];

    sram_ctrl #(
      .DATA_W(16), .ADDR_W(18),
      .WAIT_CYCLES(gi == 0 ? 1 : (gi == 1 ? 0 : 15))
    ) u_dut (
      .Clk(clk), .Rst(rst),
      .MemRead(mem_read[gi]), .MemWrite(mem_write[gi]),
      .Addr(addr[gi]), .DataIn(data_in[gi]), .DataOut(data_out[gi]),
      .Busy(busy[gi]), .Done(done[gi]),
      .Ram_EN(ram_en[gi]), .Ram_OE(ram_oe[gi]), .Ram_WE(ram_we[gi]),
      .Ram_address(ram_address[gi]), .Ram_data(rd)
    );

    // Asynchronous SRAM: drives when selected with OE low, stores while WE is low.
    assign rd = (!ram_en[gi] && !ram_oe[gi]) ? mem[ram_address[gi][7:0]] : 16'hzzzz;
    // Probe driver: a known pattern that only reads back intact when nobody else drives.
    assign rd = probe_en[gi] ? PROBE : 16'hzzzz;
    assign bus_obs[gi] = rd;

    always @(posedge clk) begin
      if (rst) mem[8'h42] <= 16'hBEEF;
      else if (!ram_en[gi] && !ram_we[gi]) mem[ram_address[gi][7:0]] <= rd;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic chk_idle(input int k, input string tag);
    chk($sformatf("%s_en%0d", tag, k),   32'(ram_en[k]), 32'd1);
    chk($sformatf("%s_oe%0d", tag, k),   32'(ram_oe[k]), 32'd1);
    chk($sformatf("%s_we%0d", tag, k),   32'(ram_we[k]), 32'd1);
    chk($sformatf("%s_busy%0d", tag, k), 32'(busy[k]),   32'd0);
    chk($sformatf("%s_done%0d", tag, k), 32'(done[k]),   32'd0);
    probe_en[k] = 1'b1;
    #1;
    chk($sformatf("%s_bus_released%0d", tag, k), 32'(bus_obs[k]), 32'(PROBE));
    probe_en[k] = 1'b0;
  endtask

  // Issue one request on instance k, held until n completions have been seen.
  task automatic do_op(input int k, input bit rd_req, input bit wr_req, input logic [17:0] a,
                       input logic [15:0] d, input logic [15:0] rd_exp, input int n);
    int   w, per, got, base;
    rec_t r;
    w = wof(k);
`ifdef SRAM_CTRL_B2B_EN
    per = w + 3;
`else
    per = w + 4;
`endif
    @(negedge clk);
    mem_read[k]  = rd_req;
    mem_write[k] = wr_req;
    addr[k]      = a;
    data_in[k]   = d;
    base = cyc;
    if (!wr_req) exp_dout[k] = rd_exp;
    for (int i = 0; i < n; i++) begin
      r.inst     = k;
      r.wr       = wr_req;
      r.addr     = a;
      r.wdata    = d;
      r.dout     = exp_dout[k];
      r.acc      = base + i * per;
      r.done_cyc = r.acc + w + 3;
      q.push_back(r);
    end
    got = 0;
    for (int c = 0; c < n * per + 30 && got < n; c++) begin
      @(negedge clk);
      if (done[k]) got++;
    end
    mem_read[k]  = 1'b0;
    mem_write[k] = 1'b0;
    if (got < n) begin
      checks++;
      errors++;
      $display("FAIL op_timeout inst %0d got %0d completions required %0d", k, got, n);
      q.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: per-cycle strobe trace of the transaction at the head, compared on Done.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && q.size() > 0) begin
        cur   = q[0];
        w_mon = wof(cur.inst);
        t_mon = cyc - cur.acc;
        if (t_mon >= 1 && t_mon <= w_mon + 3) begin
          exp_en = (t_mon == w_mon + 3) && !cur.wr;
          exp_oe = cur.wr || (t_mon == w_mon + 3);
          exp_we = !(cur.wr && t_mon >= 2 && t_mon <= w_mon + 2);
          if (ram_en[cur.inst] !== exp_en || ram_oe[cur.inst] !== exp_oe ||
              ram_we[cur.inst] !== exp_we || busy[cur.inst] !== 1'b1 ||
              ram_address[cur.inst] !== cur.addr ||
              (cur.wr && bus_obs[cur.inst] !== cur.wdata)) begin
            strobe_bad++;
            if (strobe_bad == 1)
              strobe_msg = $sformatf("cycle %0d en/oe/we/busy %b%b%b%b want %b%b%b1 addr %h bus %h",
                                     t_mon, ram_en[cur.inst], ram_oe[cur.inst], ram_we[cur.inst],
                                     busy[cur.inst], exp_en, exp_oe, exp_we,
                                     ram_address[cur.inst], bus_obs[cur.inst]);
          end
        end
      end
      for (int k = 0; k < N; k++) begin
        if (done[k]) begin
          done_seen[k]++;
          if (q.size() == 0 || q[0].inst != k) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done inst %0d got pulse at cycle %0d required none", k, cyc);
          end else begin
            cur = q.pop_front();
            checks++;
            if (cyc != cur.done_cyc) begin
              errors++;
              $display("FAIL done_cycle inst %0d got %0d required %0d", k, cyc - cur.acc, cur.done_cyc - cur.acc);
            end
            checks++;
            if (data_out[k] !== cur.dout) begin
              errors++;
              $display("FAIL data_out inst %0d got %h required %h", k, data_out[k], cur.dout);
            end
            checks++;
            if (strobe_bad != 0) begin
              errors++;
              $display("FAIL strobes inst %0d got %0d bad cycles required 0, first: %s", k, strobe_bad, strobe_msg);
            end
            $display("txn inst %0d %s addr %05h wdata %04h done at cycle %0d data_out %04h",
                     k, cur.wr ? "write" : "read ", cur.addr, cur.wdata, cyc - cur.acc, data_out[k]);
            strobe_bad = 0;
          end
        end
      end
      if (q.size() > 0 && cyc > q[0].done_cyc) begin
        checks++;
        errors++;
        $display("FAIL done_missing inst %0d got no pulse required at cycle %0d", q[0].inst, q[0].done_cyc - q[0].acc);
        strobe_bad = 0;
        void'(q.pop_front());
      end
    end
  end

  initial begin
    int n0;
    for (int k = 0; k < N; k++) begin
      mem_read[k]  = 1'b0;
      mem_write[k] = 1'b1;
      addr[k]      = '0;
      data_in[k]   = '0;
      probe_en[k]  = 1'b0;
      exp_dout[k]  = '0;
      done_seen[k] = 0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk_idle(k, "reset");
      chk($sformatf("reset_dataout%0d", k), 32'(data_out[k]), 32'd0);
      chk($sformatf("reset_addr%0d", k), 32'(ram_address[k]), 32'd0);
      mem_write[k] = 1'b0;
    end
    rst = 1'b0;

    // W=1: preloaded read, write, read back
    do_op(0, 1'b1, 1'b0, 18'h00042, 16'h0000, 16'hBEEF, 1);
    do_op(0, 1'b0, 1'b1, 18'h00042, 16'h1234, 16'h0000, 1);
    do_op(0, 1'b1, 1'b0, 18'h00042, 16'h0000, 16'h1234, 1);
    // W=0 and W=15 write then read back
    do_op(1, 1'b0, 1'b1, 18'h00055, 16'hA5A5, 16'h0000, 1);
    do_op(1, 1'b1, 1'b0, 18'h00055, 16'h0000, 16'hA5A5, 1);
    do_op(2, 1'b0, 1'b1, 18'h00055, 16'hA5A5, 16'h0000, 1);
    do_op(2, 1'b1, 1'b0, 18'h00055, 16'h0000, 16'hA5A5, 1);
    // Both requests high: write wins, DataOut stays at 0x1234
    do_op(0, 1'b1, 1'b1, 18'h00010, 16'h0F0F, 16'h0000, 1);
    do_op(0, 1'b1, 1'b0, 18'h00010, 16'h0000, 16'h0F0F, 1);
    // Held read: two completions
    do_op(0, 1'b1, 1'b0, 18'h00042, 16'h0000, 16'h1234, 2);
    chk_idle(0, "after_held");

    // Reset in ACCESS of a W=15 write
    @(negedge clk);
    mem_write[2] = 1'b1;
    addr[2]      = 18'h00020;
    data_in[2]   = 16'h7777;
    repeat (4) @(negedge clk);
    chk("abort_in_access_we", 32'(ram_we[2]), 32'd0);
    rst = 1'b1;
    mem_write[2] = 1'b0;
    @(negedge clk);
    chk_idle(2, "abort");
    n0 = done_seen[2];
    rst = 1'b0;
    for (int k = 0; k < N; k++) exp_dout[k] = '0;
    repeat (25) @(negedge clk);
    chk("abort_no_done", 32'(done_seen[2]), 32'(n0));
    chk("abort_dataout", 32'(data_out[2]), 32'd0);
    do_op(2, 1'b1, 1'b0, 18'h00042, 16'h0000, 16'hBEEF, 1);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Registered, multi-cycle controller between the MEM pipeline stage and one external asynchronous SRAM bank. It accepts a single read or write request and sequences the chip-enable, output-enable and write-enable strobes through setup, a parametrised access window and a hold cycle. It returns read data in a register and signals completion with a one-cycle `Done` pulse, so the pipeline stalls on `Busy`. It generalises the Ram1 data-memory path to any data/address width and to slower SRAM parts, and drives every SRAM strobe from a flop rather than gating it with the clock.

## Interface
- `DATA_W`, 16, data bus width
- `ADDR_W`, 18, SRAM address width
- `WAIT_CYCLES`, 1, extra access-window cycles, 0..15
- `Clk  in  1  system clock`
- `Rst  in  1  synchronous, active-high reset`
- `MemRead  in  1  read request, sampled only while idle`
- `MemWrite  in  1  write request, sampled only while idle; wins over MemRead`
- `Addr  in  ADDR_W  request address`
- `DataIn  in  DATA_W  write data`
- `DataOut  out  DATA_W  last completed read data, registered`
- `Busy  out  1  request in flight; pipeline stall`
- `Done  out  1  one-cycle completion pulse`
- `Ram_EN  out  1  SRAM chip enable, active low`
- `Ram_OE  out  1  SRAM output enable, active low`
- `Ram_WE  out  1  SRAM write enable, active low`
- `Ram_address  out  ADDR_W  SRAM address`
- `Ram_data  inout  DATA_W  SRAM data; driven only during writes, else Z`

## Operation
- FSM states: IDLE, SETUP, ACCESS, FINISH. A 4-bit counter times ACCESS.
- IDLE behaviour:
  - If `MemWrite` or `MemRead` is high, latch `Addr`, `DataIn` and the op type (write if `MemWrite`) and go to SETUP.
  - Otherwise stay in IDLE.
- SETUP, 1 cycle:
  - `Ram_EN`=0 and `Ram_address` = latched address.
  - Write: drive `Ram_data` with the latched data and keep `Ram_WE`=1.
  - Read: `Ram_OE`=0.
  - Load the counter with `WAIT_CYCLES`, then go to ACCESS.
- ACCESS, `WAIT_CYCLES`+1 cycles:
  - Write: `Ram_WE`=0.
  - Read: `Ram_OE`=0.
  - The counter decrements each cycle; leave for FINISH when it is 0.
  - On a read, `DataOut` captures `Ram_data` at the edge that leaves ACCESS.
- FINISH, 1 cycle:
  - `Ram_WE`=1 and `Ram_OE`=1.
  - Write: `Ram_EN` stays 0 and `Ram_data` stays driven (data hold).
  - Read: `Ram_EN`=1.
  - `Done`=1, then go to IDLE.
- `Busy` = 1 in SETUP, ACCESS and FINISH.
- Request inputs are ignored while `Busy`=1. The requester deasserts its request on `Done`. A request still high in IDLE starts a new access.
- `DataOut` holds its value until the next read's capture. Writes never change it.
- Simultaneous `MemRead` and `MemWrite`: a write is performed and the read is dropped.
- `Ram_WE` and `Ram_OE` are never low in the same cycle.
- `Ram_data` is never driven while `Ram_OE`=0.

## Timing
- All outputs are registered; no combinational path from request inputs to the SRAM pins.
- Request accepted at edge 0. SETUP = cycle 1, ACCESS = cycles 2..W+2, FINISH (`Done`) = cycle W+3, where W = `WAIT_CYCLES`.
- Read data is valid on `DataOut` from cycle W+3.
- Back-to-back accesses: IDLE occupies one cycle between them, so the repeat period is W+4.
- Reset values: `Ram_EN`=1, `Ram_OE`=1, `Ram_WE`=1, `Ram_data`=Z, `Ram_address`=0, `DataOut`=0, `Busy`=0, `Done`=0; FSM in IDLE.
- Reset mid-operation: at the reset edge all strobes go inactive, the bus is released and the FSM enters IDLE. No `Done` is issued for an aborted access, and a partial write is not retried.

## Configuration
- `SRAM_CTRL_B2B_EN`:
  - Defined: in FINISH, a request present on the inputs is latched and the FSM goes directly to SETUP, giving a repeat period of W+3. `Busy` stays high across the boundary and `Done` still pulses in FINISH.
  - Undefined: FINISH always returns to IDLE, as described above.

## Test plan
- Reset: hold `Rst`=1 for 3 cycles while `MemWrite`=1 -> all strobes 1, `Ram_data`=Z, `Busy`=0, `Done`=0, `DataOut`=0.
- Write, W=1: `MemWrite`, `Addr`=0x00042, `DataIn`=0x1234 -> `Ram_WE`=0 in cycles 2–3, `Ram_data`=0x1234 during cycles 1–4, `Done` in cycle 4.
- Read, W=1: SRAM model returns 0xBEEF at 0x00042 -> `Ram_OE`=0 in cycles 1–3, `DataOut`=0xBEEF and `Done` in cycle 4.
- W=0 and W=15: write then read back 0xA5A5 -> `Done` in cycles 3 and 18 respectively, and the data matches.
- Both requests high with `DataIn`=0x0F0F -> a write is performed, `Ram_OE` stays 1 throughout, `DataOut` is unchanged.
- Reset asserted in ACCESS of a write -> `Ram_WE`=1 and `Ram_data`=Z after the reset edge, no `Done`. With `SRAM_CTRL_B2B_EN` defined, two held reads complete at cycles 4 and 8 (W=1).
